// File: rtl/seg_scan_decoder.sv
// Recovers the digits shown on a multiplexed 8-digit 7-segment display by watching
// its enable/segment pins, debouncing each dwell and decoding the glyph to hex.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic [7:0]  led_cx,
    output logic [63:0] display,
    output logic [31:0] hex,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        scan_err,
    output logic        blank
);
    localparam int SW = 10;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_CAP = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [7:0]    s_en_q, s_cx_q, p_en_q, p_cx_q;
    logic [SW-1:0] stab_q, stab_d;
    logic          captured_q, captured_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    seen_q, seen_d, seen_next;
    logic [63:0]   display_q, display_d;
    logic [31:0]   hex_q, hex_d;
    logic [7:0]    dv_q, dv_d;
    logic          frame_q, frame_d;
    logic          err_q, err_d;
    logic          blank_q, blank_d;

    logic          same, onehot, capture, legal, illegal;
    logic [7:0]    inv_en;
    logic [4:0]    glyph;

    // Segments-on pattern {a..g} -> {valid, nibble}; dp is not part of the match.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   return 5'h10;
            7'h30:   return 5'h11;
            7'h6D:   return 5'h12;
            7'h79:   return 5'h13;
            7'h33:   return 5'h14;
            7'h5B:   return 5'h15;
            7'h5F:   return 5'h16;
            7'h70:   return 5'h17;
            7'h7F:   return 5'h18;
            7'h7B:   return 5'h19;
            7'h77:   return 5'h1A;
            7'h1F:   return 5'h1B;
            7'h4E:   return 5'h1C;
            7'h3D:   return 5'h1D;
            7'h4F:   return 5'h1E;
            7'h47:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        same    = ({s_en_q, s_cx_q} == {p_en_q, p_cx_q});
        inv_en  = ~s_en_q;
        onehot  = (inv_en != 8'h00) && ((inv_en & (inv_en - 8'h01)) == 8'h00);
        capture = same && !captured_q && (stab_q == STAB_CAP);
        legal   = capture && onehot;
        illegal = capture && !onehot && (s_en_q != 8'hFF);
        glyph   = decode(~s_cx_q[7:1]);

        stab_d     = !same ? '0 : (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
        captured_d = same && (captured_q || capture);

        tmo_d   = legal ? '0 : (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
        blank_d = legal ? 1'b0 : (tmo_d == TMO_MAX) ? 1'b1 : blank_q;
        err_d   = err_q | illegal;

        // Frame completion and timeout both restart the seen mask.
        seen_next = seen_q | (legal ? inv_en : 8'h00);
        frame_d   = legal && (seen_next == 8'hFF);
        seen_d    = (frame_d || (!legal && tmo_d == TMO_MAX)) ? 8'h00 : seen_next;

        display_d = display_q;
        hex_d     = hex_q;
        dv_d      = dv_q;
        for (int j = 0; j < 8; j++) begin
            if (legal && inv_en[j]) begin
                display_d[8*j +: 8] = s_cx_q;
                hex_d[4*j +: 4]     = glyph[3:0];
                dv_d[j]             = glyph[4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_en_q     <= 8'hFF;
            s_cx_q     <= 8'hFF;
            p_en_q     <= 8'hFF;
            p_cx_q     <= 8'hFF;
            stab_q     <= '0;
            captured_q <= 1'b0;
            tmo_q      <= '0;
            seen_q     <= 8'h00;
            display_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            hex_q      <= 32'h0;
            dv_q       <= 8'h00;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            s_en_q     <= led_en;
            s_cx_q     <= led_cx;
            p_en_q     <= s_en_q;
            p_cx_q     <= s_cx_q;
            stab_q     <= stab_d;
            captured_q <= captured_d;
            tmo_q      <= tmo_d;
            seen_q     <= seen_d;
            display_q  <= display_d;
            hex_q      <= hex_d;
            dv_q       <= dv_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            blank_q    <= blank_d;
        end
    end

    assign display     = display_q;
    assign hex         = hex_q;
    assign digit_valid = dv_q;
    assign frame_done  = frame_q;
    assign scan_err    = err_q;
    assign blank       = blank_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues the expected output state and
// edge count for every output change; a negedge monitor pops and compares on each change.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  led_en = 8'hFF;
    logic [7:0]  led_cx = 8'hFF;
    logic [63:0] display;
    logic [31:0] hex;
    logic [7:0]  digit_valid;
    logic        frame_done, scan_err, blank;

    seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .led_en(led_en), .led_cx(led_cx),
        .display(display), .hex(hex), .digit_valid(digit_valid),
        .frame_done(frame_done), .scan_err(scan_err), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] display;
        logic [31:0] hex;
        logic [7:0]  dv;
        logic        fd;
        logic        err;
        logic        blank;
    } outs_t;
    typedef struct {
        outs_t o;
        int    cyc;
    } exp_t;

    localparam outs_t RST_O = {64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Active-low {a,b,c,d,e,f,g,dp} codes for glyphs 0..F with dp off ('2' = 8'h25).
    logic [7:0] gcx [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    exp_t  q[$];
    outs_t cur_exp, nxt;
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic expect_at(input int c);
        exp_t e;
        if (nxt != cur_exp) begin
            e.o   = nxt;
            e.cyc = c;
            q.push_back(e);
            cur_exp = nxt;
        end
    endtask

    task automatic set_slot(input int k, input logic [7:0] cx, input logic [3:0] nib, input logic v);
        nxt.display[63-8*k -: 8] = cx;
        nxt.hex[31-4*k -: 4]     = nib;
        nxt.dv[7-k]              = v;
    endtask

    task automatic drive(input logic [7:0] en, input logic [7:0] cx, input int n);
        led_en = en;
        led_cx = cx;
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        nxt = RST_O;
        expect_at(cyc + 1);
        led_en = 8'hFF;
        led_cx = 8'hFF;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        outs_t last, now;
        exp_t  e;
        last = '0;
        forever begin
            @(negedge clk);
            now = {display, hex, digit_valid, frame_done, scan_err, blank};
            if (mon_en && now !== last) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output @%0d: got %h", cyc, now);
                end else begin
                    e = q.pop_front();
                    if (now !== e.o || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL output_event @%0d: got %h, want %h @%0d", cyc, now, e.o, e.cyc);
                    end
                end
            end
            last = now;
        end
    end

    initial begin
        int n, c;
        nxt = RST_O;
        cur_exp = RST_O;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_display", display, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reset_hex", {32'h0, hex}, 64'h0);
        check("reset_flags", {48'h0, digit_valid, 5'b0, frame_done, scan_err, blank}, 64'h0);
        mon_en = 1'b1;

        // Single digits: latency, non-glyph pattern, dp ignored.
        n = cyc; set_slot(1, 8'h25, 4'h2, 1'b1); expect_at(n + 18);
        drive(8'hBF, 8'h25, 20);
        n = cyc; set_slot(7, 8'h7F, 4'h0, 1'b0); expect_at(n + 18);
        drive(8'hFE, 8'h7F, 20);
        n = cyc; set_slot(2, 8'h10, 4'hA, 1'b1); expect_at(n + 18);
        drive(8'hDF, 8'h10, 20);
        drive(8'hFF, 8'hFF, 2);
        do_reset();

        // Full frame, glyphs 0..7.
        for (int k = 0; k < 8; k++) begin
            n = cyc;
            set_slot(k, gcx[k], 4'(k), 1'b1);
            if (k == 7) begin
                nxt.fd = 1'b1; expect_at(n + 18);
                nxt.fd = 1'b0; expect_at(n + 19);
            end else begin
                expect_at(n + 18);
            end
            drive(~(8'h80 >> k), gcx[k], 20);
        end
        check("frame1_hex", {32'h0, hex}, 64'h0123_4567);
        check("frame1_dv", {56'h0, digit_valid}, 64'hFF);
        check("frame1_mask", {56'h0, dut.seen_q}, 64'h0);

        // Illegal enable, then a second frame with glyphs 8..F.
        n = cyc; nxt.err = 1'b1; expect_at(n + 18);
        drive(8'h3F, 8'h03, 20);
        for (int k = 0; k < 8; k++) begin
            n = cyc;
            set_slot(k, gcx[k+8], 4'(k + 8), 1'b1);
            if (k == 7) begin
                nxt.fd = 1'b1; expect_at(n + 18);
                nxt.fd = 1'b0; expect_at(n + 19);
            end else begin
                expect_at(n + 18);
            end
            drive(~(8'h80 >> k), gcx[k+8], 20);
        end
        check("frame2_hex", {32'h0, hex}, 64'h89AB_CDEF);
        check("err_sticky", {63'h0, scan_err}, 64'h1);

        // Timeout: blank 100 edges after the capture, cleared by the next capture.
        n = cyc; c = n + 18; set_slot(3, 8'h03, 4'h0, 1'b1); expect_at(c);
        drive(8'hEF, 8'h03, 20);
        nxt.blank = 1'b1; expect_at(c + 100);
        drive(8'hFF, 8'hFF, 120);
        check("timeout_mask", {56'h0, dut.seen_q}, 64'h0);
        n = cyc; nxt.blank = 1'b0; set_slot(0, 8'h9F, 4'h1, 1'b1); expect_at(n + 18);
        drive(8'h7F, 8'h9F, 20);

        // Reset ten cycles into a dwell; the dwell restarts after reset.
        drive(8'hBF, 8'h25, 10);
        do_reset();
        n = cyc; set_slot(1, 8'h25, 4'h2, 1'b1); expect_at(n + 18);
        drive(8'hBF, 8'h25, 20);

        // One-cycle glitch on the segments within a dwell.
        drive(8'h7F, 8'h0D, 10);
        drive(8'h7F, 8'h99, 1);
        n = cyc; set_slot(0, 8'h49, 4'h5, 1'b1); expect_at(n + 18);
        drive(8'h7F, 8'h49, 20);

        drive(8'hFF, 8'hFF, 5);
        check("pending_events", 64'(q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
